// File: rtl/exe_stage_mdu_if.sv
// exe_stage_mdu_if: the bundle of signals between the ID/EXE registers,
// the forwarding sources (MEM, WB) and the execute stage.
//   slave  : the execute stage. It takes the EXE instruction, the forwarding
//            sources and flush. It drives ealu, z, stall and the EXE->MEM
//            registers.
//   master : upstream, the side that drives the EXE instruction.
interface exe_stage_mdu_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  logic [WIDTH-1:0] ea, eb, eimm;
  logic [2:0]       ealuc;
  logic             ealuimm, eshift;
  logic [1:0]       emd;
  logic [RADDR-1:0] exe_rs, exe_rt, exe_d;
  logic             exe_wreg, exe_m2reg, exe_wmem;
  logic             flush;
  logic             mem_wregIn, wb_wregIn;
  logic [RADDR-1:0] mem_dIn, wb_dIn;
  logic [WIDTH-1:0] mem_aluIn, wdi;
  logic [WIDTH-1:0] ealu;
  logic             z, stall;
  logic             mem_wreg, mem_m2reg, mem_wmem;
  logic [RADDR-1:0] mem_d;
  logic [WIDTH-1:0] S, MEM_Alu;

  modport slave (
    input  ea, eb, eimm, ealuc, ealuimm, eshift, emd, exe_rs, exe_rt, exe_d,
           exe_wreg, exe_m2reg, exe_wmem, flush, mem_wregIn, wb_wregIn,
           mem_dIn, wb_dIn, mem_aluIn, wdi,
    output ealu, z, stall, mem_wreg, mem_m2reg, mem_wmem, mem_d, S, MEM_Alu
  );

  modport master (
    output ea, eb, eimm, ealuc, ealuimm, eshift, emd, exe_rs, exe_rt, exe_d,
           exe_wreg, exe_m2reg, exe_wmem, flush, mem_wregIn, wb_wregIn,
           mem_dIn, wb_dIn, mem_aluIn, wdi,
    input  ealu, z, stall, mem_wreg, mem_m2reg, mem_wmem, mem_d, S, MEM_Alu
  );
endinterface

// File: rtl/exe_stage_mdu.sv
// exe_stage_mdu: execute stage with operand forwarding, an ALU, a background
// shift-add unsigned multiplier that writes HI/LO, and the EXE->MEM registers.
//   clk  : rising-edge clock
//   clrn : asynchronous reset, active high
//   bus  : exe_stage_mdu_if.slave. It carries the EXE instruction, the MEM/WB
//          forwarding sources and flush. It returns ealu, z, stall and the
//          registered MEM-side outputs.
module exe_stage_mdu #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic           clk,
  input  logic           clrn,
  exe_stage_mdu_if.slave bus
);
  localparam int SH = $clog2(WIDTH);
  localparam int CW = SH + 1;

  logic [WIDTH-1:0]   fa, fb, a_op, b_op, alu, shamt;
  logic [SH-1:0]      sh_amt;
  logic [WIDTH-1:0]   hi, lo, mplier;
  logic [2*WIDTH-1:0] mcand, acc, acc_next;
  logic [CW-1:0]      cnt;
  logic               busy, accept, bubble;
  logic               a_mem, a_wb, b_mem, b_wb;

  // MEM is the younger producer, so it wins over WB. r0 is never forwarded.
  assign a_mem = bus.mem_wregIn && (bus.mem_dIn == bus.exe_rs) && (bus.exe_rs != '0);
  assign a_wb  = bus.wb_wregIn  && (bus.wb_dIn  == bus.exe_rs) && (bus.exe_rs != '0);
  assign b_mem = bus.mem_wregIn && (bus.mem_dIn == bus.exe_rt) && (bus.exe_rt != '0);
  assign b_wb  = bus.wb_wregIn  && (bus.wb_dIn  == bus.exe_rt) && (bus.exe_rt != '0);

  always_comb begin
    fa = bus.ea;
    if (a_mem)     fa = bus.mem_aluIn;
    else if (a_wb) fa = bus.wdi;
    fb = bus.eb;
    if (b_mem)     fb = bus.mem_aluIn;
    else if (b_wb) fb = bus.wdi;
  end

  // shamt is the 5-bit field eimm[10:6], zero-extended.
  assign shamt  = (bus.eimm >> 6) & WIDTH'(31);
  assign a_op   = bus.eshift  ? shamt    : fa;
  assign b_op   = bus.ealuimm ? bus.eimm : fb;
  assign sh_amt = a_op[SH-1:0];

  always_comb begin
    alu = '0;
    case (bus.ealuc)
      3'b000: alu = a_op + b_op;
      3'b001: alu = a_op - b_op;
      3'b010: alu = a_op & b_op;
      3'b011: alu = a_op | b_op;
      3'b100: alu = a_op ^ b_op;
      3'b101: alu = b_op << sh_amt;
      3'b110: alu = b_op >> sh_amt;
      3'b111: alu = $unsigned($signed(b_op) >>> sh_amt);
      default: alu = '0;
    endcase
  end

  always_comb begin
    bus.ealu = alu;
    if (bus.emd == 2'b10)      bus.ealu = hi;
    else if (bus.emd == 2'b11) bus.ealu = lo;
  end

  assign bus.z     = (bus.ealu == '0);
  assign busy      = (cnt != '0);
  // Any HI/LO access, including a second multu, waits for the running
  // product. Flush wins because the squashed instruction has nothing to wait for.
  assign bus.stall = busy && (bus.emd != 2'b00) && !bus.flush;
  assign accept    = (bus.emd == 2'b01) && !busy && !bus.flush;
  assign bubble    = bus.flush || bus.stall;

  // mcand moves left one place per step, so it always carries mcand*2^step.
  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CW'(1);
      if (cnt == CW'(1)) {hi, lo} <= acc_next;
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, fa};
      mplier <= fb;
      acc    <= '0;
      cnt    <= CW'(WIDTH);
    end
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      bus.mem_wreg  <= 1'b0;
      bus.mem_m2reg <= 1'b0;
      bus.mem_wmem  <= 1'b0;
      bus.mem_d     <= '0;
      bus.S         <= '0;
      bus.MEM_Alu   <= '0;
    end else if (bubble) begin
      bus.mem_wreg  <= 1'b0;
      bus.mem_m2reg <= 1'b0;
      bus.mem_wmem  <= 1'b0;
      bus.mem_d     <= '0;
      bus.S         <= '0;
      bus.MEM_Alu   <= '0;
    end else begin
      bus.mem_wreg  <= bus.exe_wreg;
      bus.mem_m2reg <= bus.exe_m2reg;
      bus.mem_wmem  <= bus.exe_wmem;
      bus.mem_d     <= bus.exe_d;
      bus.S         <= fb;
      bus.MEM_Alu   <= bus.ealu;
    end
  end
endmodule

// File: tb/tb_exe_stage_mdu.sv
module tb_exe_stage_mdu;
  logic clk = 1'b0;
  logic clrn;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  exe_stage_mdu_if #(.WIDTH(32), .RADDR(5)) bus ();
  exe_stage_mdu #(.WIDTH(32), .RADDR(5)) dut (.clk(clk), .clrn(clrn), .bus(bus));

  // Reference state. The multiplier is modelled as "product pending, ready in
  // m_left edges"; HI/LO take the product on the edge where m_left reaches 0.
  int          m_left = 0;
  logic [63:0] m_prod = '0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_stall_last = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] v);
    if (r == 0) return v;
    if (bus.mem_wregIn && bus.mem_dIn == r) return bus.mem_aluIn;
    if (bus.wb_wregIn && bus.wb_dIn == r) return bus.wdi;
    return v;
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ext;
    int sh;
    sh = a % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return b << sh;
      3'd6: return b >> sh;
      default: begin
        ext = {{32{b[31]}}, b} >> sh;
        return ext[31:0];
      end
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_prod = '0; m_hi = '0; m_lo = '0; m_stall_last = 1'b0;
  endtask

  // Called at posedge+1 or later with inputs settled; returns at posedge+1.
  task automatic step();
    logic [31:0] fa, fb, a, b, e;
    logic st, bub;
    #3;
    fa = fwd(bus.exe_rs, bus.ea);
    fb = fwd(bus.exe_rt, bus.eb);
    a  = bus.eshift ? 32'((bus.eimm / 64) % 32) : fa;
    b  = bus.ealuimm ? bus.eimm : fb;
    e  = (bus.emd == 2) ? m_hi : (bus.emd == 3) ? m_lo : ref_alu(bus.ealuc, a, b);
    st = (m_left > 0) && (bus.emd != 0) && !bus.flush;
    bub = bus.flush || st;
    chk("ealu", bus.ealu, e);
    chk("z", bus.z, e == 0);
    chk("stall", bus.stall, st);
    m_stall_last = st;
    @(posedge clk);
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) {m_hi, m_lo} = m_prod;
    end else if (bus.emd == 1 && !bus.flush) begin
      m_prod = 64'(fa) * 64'(fb);
      m_left = 32;
    end
    #1;
    chk("mem_wreg", bus.mem_wreg, bub ? 0 : bus.exe_wreg);
    chk("mem_m2reg", bus.mem_m2reg, bub ? 0 : bus.exe_m2reg);
    chk("mem_wmem", bus.mem_wmem, bub ? 0 : bus.exe_wmem);
    chk("mem_d", bus.mem_d, bub ? 0 : bus.exe_d);
    chk("S", bus.S, bub ? 0 : fb);
    chk("MEM_Alu", bus.MEM_Alu, bub ? 0 : e);
  endtask

  task automatic clear_ins();
    bus.ea = 0; bus.eb = 0; bus.eimm = 0; bus.ealuc = 0; bus.ealuimm = 0;
    bus.eshift = 0; bus.emd = 0; bus.exe_rs = 0; bus.exe_rt = 0; bus.exe_d = 0;
    bus.exe_wreg = 0; bus.exe_m2reg = 0; bus.exe_wmem = 0; bus.flush = 0;
    bus.mem_wregIn = 0; bus.wb_wregIn = 0; bus.mem_dIn = 0; bus.wb_dIn = 0;
    bus.mem_aluIn = 0; bus.wdi = 0;
  endtask

  task automatic check_mem_zero(input string tag);
    chk({tag, "_wreg"}, bus.mem_wreg, 0);
    chk({tag, "_m2reg"}, bus.mem_m2reg, 0);
    chk({tag, "_wmem"}, bus.mem_wmem, 0);
    chk({tag, "_d"}, bus.mem_d, 0);
    chk({tag, "_S"}, bus.S, 0);
    chk({tag, "_alu"}, bus.MEM_Alu, 0);
  endtask

  // Holds the current instruction until the DUT drops stall; returns the
  // number of stalled cycles (bounded).
  task automatic wait_stall(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!bus.stall) break;
      n++;
      step();
    end
  endtask

  initial begin
    int n;
    clrn = 1'b1;
    clear_ins();
    #12;
    check_mem_zero("reset");
    chk("reset_stall", bus.stall, 0);
    clrn = 1'b0;
    model_reset();
    @(posedge clk); #1;

    // Forward priority: MEM beats WB.
    bus.exe_rs = 3; bus.ea = 5; bus.eb = 1; bus.exe_wreg = 1; bus.exe_d = 7;
    bus.mem_wregIn = 1; bus.mem_dIn = 3; bus.mem_aluIn = 32'h11;
    bus.wb_wregIn = 1; bus.wb_dIn = 3; bus.wdi = 32'h22;
    #1 chk("fwd_ealu", bus.ealu, 32'h12);
    step();
    chk("fwd_mem_alu", bus.MEM_Alu, 32'h12);
    // r0 never forwarded.
    bus.exe_rs = 0; bus.mem_dIn = 0; bus.wb_dIn = 0;
    #1 chk("fwd_r0", bus.ealu, 32'h6);
    step();

    // Store data comes from the forwarded rt.
    clear_ins();
    bus.exe_rt = 4; bus.ealuimm = 1; bus.eimm = 8; bus.exe_wmem = 1;
    bus.wb_wregIn = 1; bus.wb_dIn = 4; bus.wdi = 32'hDEADBEEF;
    step();
    chk("store_S", bus.S, 32'hDEADBEEF);

    // Shifts.
    clear_ins();
    bus.ealuc = 3'b111; bus.eshift = 1; bus.eimm = 4 << 6; bus.eb = 32'h80000000;
    #1 chk("sra", bus.ealu, 32'hF8000000);
    step();
    bus.ealuc = 3'b101; bus.eimm = 31 << 6; bus.eb = 1;
    #1 chk("sll31", bus.ealu, 32'h80000000);
    chk("sll31_z", bus.z, 0);
    step();

    // multu 0xFFFFFFFF^2, then mfhi/mflo.
    clear_ins();
    bus.emd = 2'b01; bus.ea = 32'hFFFFFFFF; bus.eb = 32'hFFFFFFFF;
    step();
    bus.emd = 2'b10; bus.exe_wreg = 1; bus.exe_d = 9;
    wait_stall(n);
    chk("mfhi_stall_len", n, 32);
    chk("mfhi", bus.ealu, 32'hFFFFFFFE);
    step();
    bus.emd = 2'b11;
    #1 chk("mflo", bus.ealu, 32'h1);
    step();

    // Flush with multu in EXE: not accepted, MEM bubble.
    bus.emd = 2'b01; bus.flush = 1; bus.ea = 3; bus.eb = 5;
    step();
    chk("flush_mul_bubble", bus.mem_wreg, 0);
    bus.flush = 0; bus.emd = 2'b10;
    #1 chk("flush_mul_not_busy", bus.stall, 0);
    step();

    // Flush a stalled mfhi; the multiply still completes.
    bus.emd = 2'b01; bus.ea = 3; bus.eb = 5; bus.exe_wreg = 0;
    step();
    bus.emd = 2'b10; bus.flush = 1; bus.exe_wreg = 1;
    #1 chk("flush_stall", bus.stall, 0);
    step();
    chk("flush_stall_bubble", bus.mem_wreg, 0);
    bus.flush = 0;
    wait_stall(n);
    chk("flush_mfhi", bus.ealu, 32'h0);
    step();
    bus.emd = 2'b11;
    #1 chk("flush_mflo", bus.ealu, 32'd15);
    step();

    // Reset mid-multiply (cnt == 10 after 22 steps).
    clear_ins();
    bus.emd = 2'b01; bus.ea = 7; bus.eb = 9;
    step();
    bus.emd = 2'b00; bus.ea = 32'h1234; bus.eb = 1; bus.exe_wreg = 1; bus.exe_d = 2;
    bus.exe_rt = 6; bus.wb_wregIn = 1; bus.wb_dIn = 6; bus.wdi = 32'h55;
    repeat (22) step();
    bus.emd = 2'b11;
    #1 chk("pre_reset_stall", bus.stall, 1);
    clrn = 1'b1;
    #1;
    check_mem_zero("midreset");
    chk("midreset_stall", bus.stall, 0);
    chk("midreset_lo", bus.ealu, 0);
    clrn = 1'b0;
    model_reset();
    step();
    chk("post_reset_mflo", bus.MEM_Alu, 0);

    // Randomized traffic against the model.
    clear_ins();
    for (int i = 0; i < 600; i++) begin
      int r;
      if (!m_stall_last) begin
        r = $urandom_range(0, 9);
        bus.emd = (r == 0) ? 2'b01 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
        bus.ea = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
        bus.eb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        bus.eimm = $urandom;
        bus.ealuc = 3'($urandom_range(0, 7));
        bus.ealuimm = 1'($urandom_range(0, 1));
        bus.eshift = ($urandom_range(0, 3) == 0);
        bus.exe_rs = 5'($urandom_range(0, 3));
        bus.exe_rt = 5'($urandom_range(0, 3));
        bus.exe_d = 5'($urandom);
        bus.exe_wreg = 1'($urandom_range(0, 1));
        bus.exe_m2reg = 1'($urandom_range(0, 1));
        bus.exe_wmem = 1'($urandom_range(0, 1));
      end
      bus.flush = ($urandom_range(0, 19) == 0);
      bus.mem_wregIn = 1'($urandom_range(0, 1));
      bus.wb_wregIn = 1'($urandom_range(0, 1));
      bus.mem_dIn = 5'($urandom_range(0, 3));
      bus.wb_dIn = 5'($urandom_range(0, 3));
      bus.mem_aluIn = $urandom;
      bus.wdi = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
